imm_ext_ctrl: RTL and testbench

- ID-stage immediate controller for the pipelined MIPS core.
- Decodes each fetched instruction's opcode to select the extension mode: sign, zero, LUI, branch offset, jump target or shamt.
- Produces the extended operand and registers it toward ID/EX through a valid/ready interface with a 2-entry skid buffer.
- Supports pipeline stall (backpressure) and flush.

---
 rtl/imm_ext_ctrl_if.sv | 25 ++
 rtl/imm_ext_ctrl.sv | 140 ++++++++++++++
 tb/tb_imm_ext_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_ctrl_if.sv
// Valid/ready bus between the IF/ID instruction source and the ID/EX sink
// around the immediate controller. The master drives instructions in and
// accepts extended operands out. The slave is the controller itself.
interface imm_ext_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              InValid;
  logic              InReady;
  logic [31:0]       Instr;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] ImmOut;
  logic [2:0]        ExtMode;
  logic              Illegal;

  modport master (
    output InValid, Instr, OutReady,
    input  InReady, OutValid, ImmOut, ExtMode, Illegal
  );

  modport slave (
    input  InValid, Instr, OutReady,
    output InReady, OutValid, ImmOut, ExtMode, Illegal
  );
endinterface

// File: rtl/imm_ext_ctrl.sv
// ID-stage immediate controller: decodes the opcode of each incoming MIPS
// instruction into an extension mode, builds the extended operand and hands
// it to ID/EX through an output register backed by a one-entry skid register.
module imm_ext_ctrl #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Flush,
  imm_ext_ctrl_if.slave bus
);

  localparam logic [2:0] MODE_SIGN   = 3'd0;
  localparam logic [2:0] MODE_ZERO   = 3'd1;
  localparam logic [2:0] MODE_LUI    = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_JUMP   = 3'd4;
  localparam logic [2:0] MODE_SHAMT  = 3'd5;

  // Returns {illegal, mode}; unrecognised opcodes report SHAMT as their mode.
  function automatic logic [3:0] decode_mode(input logic [5:0] op);
    if ((op >= 6'h08 && op <= 6'h0B) || (op >= 6'h20 && op <= 6'h2E))
      return {1'b0, MODE_SIGN};
    else if (op >= 6'h0C && op <= 6'h0E)
      return {1'b0, MODE_ZERO};
    else if (op == 6'h0F)
      return {1'b0, MODE_LUI};
    else if (op == 6'h01 || (op >= 6'h04 && op <= 6'h07))
      return {1'b0, MODE_BRANCH};
    else if (op == 6'h02 || op == 6'h03)
      return {1'b0, MODE_JUMP};
    else if (op == 6'h00)
      return {1'b0, MODE_SHAMT};
    else
      return {1'b1, MODE_SHAMT};
  endfunction

  // Width casts of signed operands sign-extend (or truncate) to DATA_W, which
  // keeps every mode correct across the whole legal DATA_W range.
  function automatic logic [DATA_W-1:0] extend(input logic [31:0] instr,
                                               input logic [2:0]  mode,
                                               input logic        ill);
    logic signed [IMM_W-1:0]   imm;
    logic signed [2*IMM_W-1:0] lui;
    logic signed [IMM_W+1:0]   boff;
    imm  = instr[IMM_W-1:0];
    lui  = {imm, {IMM_W{1'b0}}};
    boff = {imm, 2'b00};
    if (ill)
      return '0;
    case (mode)
      MODE_SIGN:   return DATA_W'(imm);
      MODE_ZERO:   return DATA_W'($unsigned(imm));
      MODE_LUI:    return DATA_W'(lui);
      MODE_BRANCH: return DATA_W'(boff);
      MODE_JUMP:   return DATA_W'({instr[25:0], 2'b00});
      MODE_SHAMT:  return DATA_W'(instr[10:6]);
      default:     return '0;
    endcase
  endfunction

  logic              accept;
  logic              drain;

  // stage p0: combinational decode of the presented instruction
  logic [3:0]        dec_p0;
  logic [2:0]        mode_p0;
  logic              ill_p0;
  logic [DATA_W-1:0] imm_p0;

  // stage p1: output register (O) and skid register (S)
  logic              vld_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [2:0]        mode_p1;
  logic              ill_p1;
  logic              skid_vld_p1;
  logic [DATA_W-1:0] skid_imm_p1;
  logic [2:0]        skid_mode_p1;
  logic              skid_ill_p1;

  assign dec_p0  = decode_mode(bus.Instr[31:26]);
  assign ill_p0  = dec_p0[3];
  assign mode_p0 = dec_p0[2:0];
  assign imm_p0  = extend(bus.Instr, mode_p0, ill_p0);

  // InReady comes straight from the skid valid flop, so it is registered.
  assign bus.InReady = !skid_vld_p1;
  assign accept      = bus.InValid & bus.InReady;
  assign drain       = vld_p1 & bus.OutReady;

  assign bus.OutValid = vld_p1;
  assign bus.ImmOut   = imm_p1;
  assign bus.ExtMode  = mode_p1;
  assign bus.Illegal  = ill_p1;

  // Move entries through O and S in FIFO order; flush drops both and any
  // same-cycle accept, while a same-cycle drain has already been taken.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1       <= 1'b0;
      imm_p1       <= '0;
      mode_p1      <= '0;
      ill_p1       <= 1'b0;
      skid_vld_p1  <= 1'b0;
      skid_imm_p1  <= '0;
      skid_mode_p1 <= '0;
      skid_ill_p1  <= 1'b0;
    end else if (Flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || drain) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        imm_p1      <= skid_imm_p1;
        mode_p1     <= skid_mode_p1;
        ill_p1      <= skid_ill_p1;
        skid_vld_p1 <= accept;
        if (accept) begin
          skid_imm_p1  <= imm_p0;
          skid_mode_p1 <= mode_p0;
          skid_ill_p1  <= ill_p0;
        end
      end else begin
        vld_p1 <= accept;
        if (accept) begin
          imm_p1  <= imm_p0;
          mode_p1 <= mode_p0;
          ill_p1  <= ill_p0;
        end
      end
    end else if (accept) begin
      skid_vld_p1  <= 1'b1;
      skid_imm_p1  <= imm_p0;
      skid_mode_p1 <= mode_p0;
      skid_ill_p1  <= ill_p0;
    end
  end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Directed bench for imm_ext_ctrl: a table of single instructions with
// hand-computed extensions, then stall, flush and reset sequences.
module tb_imm_ext_ctrl;

  logic Clk;
  logic Reset;
  logic Flush;

  int tests;
  int failed;

  imm_ext_ctrl_if #(.DATA_W(32)) bus ();

  imm_ext_ctrl #(.DATA_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Flush (Flush),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  mode;
    logic        ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [31:0] imm,
                         input logic [2:0] mode, input logic ill);
    chk({name, " valid"}, 32'(bus.OutValid), 32'd1);
    chk({name, " imm"},   bus.ImmOut, imm);
    chk({name, " mode"},  32'(bus.ExtMode), 32'(mode));
    chk({name, " ill"},   32'(bus.Illegal), 32'(ill));
  endtask

  // Present one instruction for exactly one cycle; returns just after the edge.
  task automatic push(input logic [31:0] instr);
    @(negedge Clk);
    bus.InValid = 1'b1;
    bus.Instr   = instr;
    @(posedge Clk);
    #1;
    bus.InValid = 1'b0;
  endtask

  function automatic logic [31:0] addi(input logic [15:0] imm);
    return {16'h2008, imm};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests  = 0;
    failed = 0;
    vecs[0]  = '{32'h2008FFFC, 32'hFFFFFFFC, 3'd0, 1'b0}; // ADDI
    vecs[1]  = '{32'h3508FFFC, 32'h0000FFFC, 3'd1, 1'b0}; // ORI
    vecs[2]  = '{32'h3C081234, 32'h12340000, 3'd2, 1'b0}; // LUI
    vecs[3]  = '{32'h1109FFFF, 32'hFFFFFFFC, 3'd3, 1'b0}; // BEQ
    vecs[4]  = '{32'h08000010, 32'h00000040, 3'd4, 1'b0}; // J
    vecs[5]  = '{32'hFC000000, 32'h00000000, 3'd5, 1'b1}; // op 0x3F
    vecs[6]  = '{32'h00000140, 32'h00000005, 3'd5, 1'b0}; // SLL shamt 5
    vecs[7]  = '{32'h8C001234, 32'h00001234, 3'd0, 1'b0}; // LW
    vecs[8]  = '{32'h24008000, 32'hFFFF8000, 3'd0, 1'b0}; // ADDIU
    vecs[9]  = '{32'h30008000, 32'h00008000, 3'd1, 1'b0}; // ANDI
    vecs[10] = '{32'h04000001, 32'h00000004, 3'd3, 1'b0}; // REGIMM
    vecs[11] = '{32'h0FFFFFFF, 32'h0FFFFFFC, 3'd4, 1'b0}; // JAL max target
    vecs[12] = '{32'h40000000, 32'h00000000, 3'd5, 1'b1}; // op 0x10
    vecs[13] = '{32'hBC00FFFF, 32'h00000000, 3'd5, 1'b1}; // op 0x2F
    vecs[14] = '{32'hB800FFFF, 32'hFFFFFFFF, 3'd0, 1'b0}; // op 0x2E
    vecs[15] = '{32'h3C088000, 32'h80000000, 3'd2, 1'b0}; // LUI top bit

    Reset        = 1'b1;
    Flush        = 1'b0;
    bus.InValid  = 1'b0;
    bus.Instr    = '0;
    bus.OutReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst valid", 32'(bus.OutValid), 32'd0);
    chk("rst imm",   bus.ImmOut, 32'd0);
    chk("rst mode",  32'(bus.ExtMode), 32'd0);
    chk("rst ill",   32'(bus.Illegal), 32'd0);
    chk("rst ready", 32'(bus.InReady), 32'd1);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      push(vecs[i].instr);
      chk_out($sformatf("vec%0d", i), vecs[i].imm, vecs[i].mode, vecs[i].ill);
    end
    @(posedge Clk);
    #1;
    chk("idle valid", 32'(bus.OutValid), 32'd0);

    // back-to-back ORI then LUI
    @(negedge Clk);
    bus.InValid = 1'b1;
    bus.Instr   = 32'h3508FFFC;
    @(posedge Clk);
    #1;
    chk_out("b2b ori", 32'h0000FFFC, 3'd1, 1'b0);
    @(negedge Clk);
    bus.Instr = 32'h3C081234;
    @(posedge Clk);
    #1;
    chk_out("b2b lui", 32'h12340000, 3'd2, 1'b0);
    bus.InValid = 1'b0;
    @(posedge Clk);
    #1;

    // stall: three ADDIs into a blocked sink
    @(negedge Clk);
    bus.OutReady = 1'b0;
    push(addi(16'd1));
    chk_out("stall o1", 32'd1, 3'd0, 1'b0);
    chk("stall rdy1", 32'(bus.InReady), 32'd1);
    push(addi(16'd2));
    chk_out("stall hold", 32'd1, 3'd0, 1'b0);
    chk("stall rdy2", 32'(bus.InReady), 32'd0);
    push(addi(16'd3));
    chk_out("stall drop", 32'd1, 3'd0, 1'b0);
    chk("stall rdy3", 32'(bus.InReady), 32'd0);
    @(negedge Clk);
    bus.OutReady = 1'b1;
    #1;
    chk_out("drain 1", 32'd1, 3'd0, 1'b0);
    @(posedge Clk);
    #1;
    chk_out("drain 2", 32'd2, 3'd0, 1'b0);
    chk("drain rdy", 32'(bus.InReady), 32'd1);
    @(posedge Clk);
    #1;
    chk("drain empty", 32'(bus.OutValid), 32'd0);
    push(addi(16'd3));
    chk_out("resend 3", 32'd3, 3'd0, 1'b0);
    @(posedge Clk);
    #1;

    // flush with both entries full and an instruction offered
    @(negedge Clk);
    bus.OutReady = 1'b0;
    push(addi(16'h11));
    push(addi(16'h22));
    chk("pre-flush rdy", 32'(bus.InReady), 32'd0);
    @(negedge Clk);
    Flush       = 1'b1;
    bus.InValid = 1'b1;
    bus.Instr   = addi(16'h33);
    @(posedge Clk);
    #1;
    chk("flush valid", 32'(bus.OutValid), 32'd0);
    chk("flush rdy",   32'(bus.InReady), 32'd1);
    @(negedge Clk);
    Flush        = 1'b0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    repeat (2) begin
      @(posedge Clk);
      #1;
      chk("post-flush valid", 32'(bus.OutValid), 32'd0);
    end
    push(addi(16'h44));
    chk_out("post-flush new", 32'h44, 3'd0, 1'b0);
    @(posedge Clk);
    #1;

    // reset in the middle of a full stall, with an illegal entry in O
    @(negedge Clk);
    bus.OutReady = 1'b0;
    push(32'hFC00ABCD);
    push(addi(16'h55));
    chk("pre-rst rdy", 32'(bus.InReady), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("mid-rst valid", 32'(bus.OutValid), 32'd0);
    chk("mid-rst imm",   bus.ImmOut, 32'd0);
    chk("mid-rst mode",  32'(bus.ExtMode), 32'd0);
    chk("mid-rst ill",   32'(bus.Illegal), 32'd0);
    chk("mid-rst rdy",   32'(bus.InReady), 32'd1);
    @(negedge Clk);
    Reset        = 1'b0;
    bus.OutReady = 1'b1;
    push(32'h2008FFFC);
    chk_out("after rst", 32'hFFFFFFFC, 3'd0, 1'b0);
    @(posedge Clk);
    #1;
    chk("after rst empty", 32'(bus.OutValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
